// File: rtl/alux_datapath_pkg.sv
// rtl/alux_datapath_pkg.sv - shared widths, opcodes, write modes and write-merge helpers
package alux_datapath_pkg;

  localparam int W    = 64;
  localparam int NREG = 16;
  localparam int SELW = $clog2(NREG);

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_INC  = 4'b1110;
  localparam logic [3:0] OP_DEC  = 4'b1111;

  localparam logic [1:0] WR_FULL  = 2'b00;
  localparam logic [1:0] WR_LOW   = 2'b01;
  localparam logic [1:0] WR_HIGH  = 2'b10;
  localparam logic [1:0] WR_BSWAP = 2'b11;

  function automatic logic [W-1:0] byte_swap(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 8; i++) begin
      r[W-8-8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // New register contents for a write, given the mode and the current contents
  function automatic logic [W-1:0] write_merge(input logic [1:0] mode,
                                               input logic [W-1:0] din,
                                               input logic [W-1:0] old);
    logic [W-1:0] r;
    case (mode)
      WR_LOW:   r = {old[W-1:W/2], din[W/2-1:0]};
      WR_HIGH:  r = {din[W-1:W/2], old[W/2-1:0]};
      WR_BSWAP: r = byte_swap(din);
      default:  r = din;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alux_datapath_alux.sv
// rtl/alux_datapath_alux.sv - 64-bit ALU with registered result and done strobe
module alux
  import alux_datapath_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opr,
  input  logic         start,
  output logic [W-1:0] outAB,
  output logic         done
);

  logic [W-1:0] res;
  logic [5:0]   sh;

  assign sh = b[5:0];

  always_comb begin
    res = '0;
    case (opr)
      OP_A:    res = a;
      OP_B:    res = b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $signed(a) >>> sh;
      OP_MUL:  res = a * b;
      OP_SLT:  res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(W-1){1'b0}}, (a < b)};
      OP_INC:  res = a + 1'b1;
      OP_DEC:  res = a - 1'b1;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outAB <= '0;
      done  <= 1'b0;
    end else if (start) begin
      outAB <= res;
      done  <= 1'b1;
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/alux_datapath_reg_bank.sv
// rtl/alux_datapath_reg_bank.sv - 16 x 64-bit register bank with two registered read ports
module reg_bank
  import alux_datapath_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            regwen,
  input  logic [W-1:0]    inA,
  input  logic [SELW-1:0] selwreg,
  input  logic [1:0]      endwreg,
  input  logic [SELW-1:0] seloutA,
  input  logic [SELW-1:0] seloutB,
  input  logic            cnstA,
  input  logic            cnstB,
  input  logic            enrregA,
  input  logic            enrregB,
  output logic [W-1:0]    outA,
  output logic [W-1:0]    outB
);

  logic [W-1:0] regs [NREG];
  logic [W-1:0] wdata;

  assign wdata = write_merge(endwreg, inA, regs[selwreg]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (regwen) begin
      regs[selwreg] <= wdata;
    end
  end

  // Reads sample the pre-edge array, so a same-index write shows up one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outA <= '0;
      outB <= '0;
    end else begin
      if (enrregA) begin
        outA <= cnstA ? {{(W-SELW){1'b0}}, seloutA} : regs[seloutA];
      end
      if (enrregB) begin
        outB <= cnstB ? {{(W-SELW){1'b0}}, seloutB} : regs[seloutB];
      end
    end
  end

endmodule

// File: rtl/alux_datapath.sv
// rtl/alux_datapath.sv - top: register bank read ports feed the ALU operands
module alux_datapath
  import alux_datapath_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            regwen,
  input  logic [W-1:0]    inA,
  input  logic [SELW-1:0] selwreg,
  input  logic [1:0]      endwreg,
  input  logic [SELW-1:0] seloutA,
  input  logic [SELW-1:0] seloutB,
  input  logic            cnstA,
  input  logic            cnstB,
  input  logic            enrregA,
  input  logic            enrregB,
  input  logic [3:0]      opr,
  input  logic            start,
  output logic [W-1:0]    outA,
  output logic [W-1:0]    outB,
  output logic [W-1:0]    outAB,
  output logic            done
);

  reg_bank u_reg_bank (
    .clock   (clock),
    .reset   (reset),
    .regwen  (regwen),
    .inA     (inA),
    .selwreg (selwreg),
    .endwreg (endwreg),
    .seloutA (seloutA),
    .seloutB (seloutB),
    .cnstA   (cnstA),
    .cnstB   (cnstB),
    .enrregA (enrregA),
    .enrregB (enrregB),
    .outA    (outA),
    .outB    (outB)
  );

  alux u_alux (
    .clock (clock),
    .reset (reset),
    .a     (outA),
    .b     (outB),
    .opr   (opr),
    .start (start),
    .outAB (outAB),
    .done  (done)
  );

endmodule

// File: tb/tb_alux_datapath.sv
// tb/tb_alux_datapath.sv - self-checking bench: behavioural model compared every cycle plus literal vectors
module tb_alux_datapath;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        regwen = 1'b0;
  logic [63:0] inA = '0;
  logic [3:0]  selwreg = '0;
  logic [1:0]  endwreg = '0;
  logic [3:0]  seloutA = '0;
  logic [3:0]  seloutB = '0;
  logic        cnstA = 1'b0;
  logic        cnstB = 1'b0;
  logic        enrregA = 1'b0;
  logic        enrregB = 1'b0;
  logic [3:0]  opr = '0;
  logic        start = 1'b0;
  logic [63:0] outA, outB, outAB;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  alux_datapath dut (
    .clock(clock), .reset(reset), .regwen(regwen), .inA(inA), .selwreg(selwreg),
    .endwreg(endwreg), .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .opr(opr), .start(start),
    .outA(outA), .outB(outB), .outAB(outAB), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference behaviour from the datasheet rules
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] msb;
    int s;
    msb = 64'h8000_0000_0000_0000;
    s = int'(b % 64);
    case (op)
      4'd0:  return a;
      4'd1:  return b;
      4'd2:  return a + b;
      4'd3:  return a + ~b + 64'd1;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return a << s;
      4'd9:  return a >> s;
      4'd10: return a[63] ? ~((~a) >> s) : (a >> s);
      4'd11: return a * b;
      4'd12: return ((a ^ msb) < (b ^ msb)) ? 64'd1 : 64'd0;
      4'd13: return (a < b) ? 64'd1 : 64'd0;
      4'd14: return a + 64'd1;
      default: return a - 64'd1;
    endcase
  endfunction

  function automatic logic [63:0] ref_write(input logic [1:0] mode, input logic [63:0] d,
                                            input logic [63:0] old);
    logic [63:0] r;
    case (mode)
      2'b01: r = (old & 64'hFFFF_FFFF_0000_0000) | (d & 64'h0000_0000_FFFF_FFFF);
      2'b10: r = (d & 64'hFFFF_FFFF_0000_0000) | (old & 64'h0000_0000_FFFF_FFFF);
      2'b11: begin
        r = '0;
        for (int k = 0; k < 8; k++) r = r | (((d >> (8 * k)) & 64'hFF) << (8 * (7 - k)));
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [63:0] m_reg [16];
  logic [63:0] m_a, m_b, m_ab;
  logic        m_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= '0;
      m_a <= '0; m_b <= '0; m_ab <= '0; m_done <= 1'b0;
    end else begin
      if (enrregA) m_a <= cnstA ? 64'(seloutA) : m_reg[seloutA];
      if (enrregB) m_b <= cnstB ? 64'(seloutB) : m_reg[seloutB];
      if (start) m_ab <= ref_alu(opr, m_a, m_b);
      m_done <= start;
      if (regwen) m_reg[selwreg] <= ref_write(endwreg, inA, m_reg[selwreg]);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("model_outA", outA, m_a);
      check("model_outB", outB, m_b);
      check("model_outAB", outAB, m_ab);
      check("model_done", {63'd0, done}, {63'd0, m_done});
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [1:0] mode, input logic [63:0] d);
    regwen = 1'b1; selwreg = idx; endwreg = mode; inA = d;
    tick();
    regwen = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic [63:0] exp);
    wr(4'd1, 2'b00, a);
    wr(4'd2, 2'b00, b);
    seloutA = 4'd1; seloutB = 4'd2; enrregA = 1'b1; enrregB = 1'b1;
    tick();
    enrregA = 1'b0; enrregB = 1'b0; opr = op; start = 1'b1;
    tick();
    start = 1'b0;
    check(nm, outAB, exp);
  endtask

  initial begin
    logic [63:0] v;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    check("reset_outA", outA, 64'd0);
    check("reset_outAB", outAB, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      v = 64'd12321978053717715840 + 64'(16 * i);
      wr(4'(i), 2'b00, v);
      seloutA = 4'(i); seloutB = 4'(i); enrregA = 1'b1; enrregB = 1'b1;
      tick();
      enrregA = 1'b0; enrregB = 1'b0; opr = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("sweep_outAB", outAB, v);
      check("sweep_done", {63'd0, done}, 64'd1);
    end

    wr(4'd3, 2'b00, 64'd0);
    wr(4'd3, 2'b01, 64'h1111_2222_3333_4444);
    seloutA = 4'd3; enrregA = 1'b1;
    tick();
    check("mode01", outA, 64'h0000_0000_3333_4444);
    wr(4'd3, 2'b10, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check("mode10", outA, 64'hAAAA_BBBB_3333_4444);
    wr(4'd3, 2'b11, 64'h0102_0304_0506_0708);
    tick();
    check("mode11", outA, 64'h0807_0605_0403_0201);

    // read-during-write on the same index
    seloutA = 4'd5; enrregA = 1'b1;
    wr(4'd5, 2'b00, 64'hDEAD_BEEF_0000_0001);
    check("rdw_old", outA, 64'd12321978053717715840 + 64'd80);
    tick();
    check("rdw_new", outA, 64'hDEAD_BEEF_0000_0001);
    enrregA = 1'b0;

    run_op("add", 64'd7, 64'd5, 4'd2, 64'd12);
    run_op("sub", 64'd7, 64'd5, 4'd3, 64'd2);
    run_op("and", 64'd7, 64'd5, 4'd4, 64'd5);
    run_op("or", 64'd7, 64'd5, 4'd5, 64'd7);
    run_op("xor", 64'd7, 64'd5, 4'd6, 64'd2);
    run_op("not", 64'd7, 64'd5, 4'd7, 64'hFFFF_FFFF_FFFF_FFF8);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 64'd0);
    run_op("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd12, 64'd1);
    run_op("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd13, 64'd0);
    run_op("sll", 64'd3, 64'd2, 4'd8, 64'd12);
    run_op("mul", 64'd3, 64'd2, 4'd11, 64'd6);
    run_op("opb", 64'd3, 64'd2, 4'd1, 64'd2);
    run_op("srl", 64'h8000_0000_0000_0000, 64'd63, 4'd9, 64'd1);
    run_op("dec", 64'd0, 64'd0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("inc", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd14, 64'd0);
    run_op("sra", 64'h8000_0000_0000_0000, 64'd63, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF);

    // read enable held low: outA keeps its value across writes
    enrregA = 1'b0; seloutA = 4'd1;
    wr(4'd1, 2'b00, 64'h1234);
    tick();
    check("hold_outA", outA, 64'h8000_0000_0000_0000);

    cnstB = 1'b1; seloutB = 4'd9; enrregB = 1'b1;
    tick();
    check("cnstB", outB, 64'd9);
    cnstB = 1'b0; enrregB = 1'b0;

    opr = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("pulse_done", {63'd0, done}, 64'd1);
    tick();
    check("pulse_done_low", {63'd0, done}, 64'd0);
    check("hold_outAB", outAB, 64'h8000_0000_0000_0000);
    opr = 4'd2;
    tick();
    check("hold_outAB2", outAB, 64'h8000_0000_0000_0000);

    // asynchronous reset mid-operation
    start = 1'b1; enrregA = 1'b1; enrregB = 1'b1;
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("areset_outA", outA, 64'd0);
    check("areset_outB", outB, 64'd0);
    check("areset_outAB", outAB, 64'd0);
    check("areset_done", {63'd0, done}, 64'd0);
    start = 1'b0; enrregA = 1'b0; enrregB = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_done", {63'd0, done}, 64'd0);
    seloutA = 4'd1; enrregA = 1'b1;
    tick();
    check("post_reset_reg", outA, 64'd0);
    enrregA = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
